// File: rtl/dfh_scratch_walker.sv
// dfh_scratch_walker: walks a DFH chain, matches each GUID against a table and scratch-tests matched features.
// Ports: clk/rst_n (async active-low); start/base_addr launch a walk; tbl_guid/tbl_scratch hold
// per-feature GUIDs and scratch offsets; req_*/rsp_* form a single-outstanding CSR bus;
// busy/done/error report progress; found_mask/pass_mask report per-feature results.
// Define DFH_WALK_RESTORE_EN to save and restore each original scratch value around the test.
module dfh_scratch_walker #(
  parameter int          NUM_FEAT    = 9,
  parameter int          ADDR_W      = 24,
  parameter int          MAX_HOPS    = 64,
  parameter int          RSP_TIMEOUT = 256,
  parameter logic [63:0] PATTERN     = 64'hA5A5_5A5A_0F0F_F0F0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [NUM_FEAT*128-1:0] tbl_guid,
  input  logic [NUM_FEAT*16-1:0]  tbl_scratch,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [63:0]             req_wdata,
  input  logic                    rsp_valid,
  input  logic [63:0]             rsp_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [NUM_FEAT-1:0]     found_mask,
  output logic [NUM_FEAT-1:0]     pass_mask
);
  localparam int IW = NUM_FEAT > 1 ? $clog2(NUM_FEAT) : 1;
  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, RD_DFH, RD_GUID_L, RD_GUID_H, MATCH, RD_ORIG, WR_SCR,
    RD_SCR, CHECK, WR_RESTORE, NEXT, DONE
  } state_t;

`ifdef DFH_WALK_RESTORE_EN
  localparam state_t SCR_FIRST = RD_ORIG;
  localparam state_t SCR_LAST  = WR_RESTORE;
`else
  localparam state_t SCR_FIRST = WR_SCR;
  localparam state_t SCR_LAST  = NEXT;
`endif

  state_t              state_q, state_d;
  logic                req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d, addr_q, addr_d;
  logic [63:0]         req_wdata_q, req_wdata_d;
  logic                pend_q, pend_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [24:0]         dfh_q, dfh_d;
  logic [63:0]         gl_q, gl_d, gh_q, gh_d, scr_q, scr_d, orig_q, orig_d;
  logic [IW-1:0]       idx_q, idx_d, midx;
  logic [HW-1:0]       hops_q, hops_d;
  logic [NUM_FEAT-1:0] found_q, found_d, pass_q, pass_d;
  logic                err_q, err_d;
  logic                is_rd, is_wr, hit, ok;
  logic [15:0]         scr_off;
  logic [ADDR_W-1:0]   acc_addr;
  state_t              adv;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit  = 1'b0;
    midx = '0;
    for (int i = NUM_FEAT - 1; i >= 0; i--)
      if (tbl_guid[128*i +: 128] == {gh_q, gl_q}) begin
        hit  = 1'b1;
        midx = IW'(i);
      end
  end

  always_comb begin
    is_rd    = state_q inside {RD_DFH, RD_GUID_L, RD_GUID_H, RD_ORIG, RD_SCR};
    is_wr    = state_q inside {WR_SCR, WR_RESTORE};
    scr_off  = tbl_scratch[16*idx_q +: 16];
    ok       = scr_q == (PATTERN ^ 64'(idx_q));
    acc_addr = state_q == RD_DFH    ? addr_q :
               state_q == RD_GUID_L ? addr_q + ADDR_W'(8) :
               state_q == RD_GUID_H ? addr_q + ADDR_W'(16) : addr_q + ADDR_W'(scr_off);
    adv      = state_q == RD_DFH    ? RD_GUID_L :
               state_q == RD_GUID_L ? RD_GUID_H :
               state_q == RD_GUID_H ? MATCH :
               state_q == RD_ORIG   ? WR_SCR :
               state_q == WR_SCR    ? RD_SCR :
               state_q == RD_SCR    ? CHECK : NEXT;
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    pend_d      = pend_q;
    tmr_d       = tmr_q;
    addr_d      = addr_q;
    dfh_d       = dfh_q;
    gl_d        = gl_q;
    gh_d        = gh_q;
    scr_d       = scr_q;
    orig_d      = orig_q;
    idx_d       = idx_q;
    hops_d      = hops_q;
    found_d     = found_q;
    pass_d      = pass_q;
    err_d       = err_q;
    // Bus access states: issue once, then wait for accept (and response for reads).
    if ((is_rd || is_wr) && !req_valid_q && !pend_q) begin
      req_valid_d = 1'b1;
      req_write_d = is_wr;
      req_addr_d  = acc_addr;
      req_wdata_d = !is_wr ? '0 : state_q == WR_RESTORE ? orig_q : PATTERN ^ 64'(idx_q);
    end
    if (req_valid_q && req_ready) begin
      req_valid_d = 1'b0;
      state_d     = req_write_q ? adv : state_q;
      pend_d      = !req_write_q;
      tmr_d       = '0;
    end
    if (pend_q && rsp_valid) begin
      pend_d  = 1'b0;
      state_d = adv;
      dfh_d   = state_q == RD_DFH    ? rsp_rdata[40:16] : dfh_q;
      hops_d  = state_q == RD_DFH    ? hops_q + 1'b1 : hops_q;
      gl_d    = state_q == RD_GUID_L ? rsp_rdata : gl_q;
      gh_d    = state_q == RD_GUID_H ? rsp_rdata : gh_q;
      orig_d  = state_q == RD_ORIG   ? rsp_rdata : orig_q;
      scr_d   = state_q == RD_SCR    ? rsp_rdata : scr_q;
    end else if (pend_q && tmr_q == TW'(RSP_TIMEOUT - 1)) begin
      pend_d  = 1'b0;
      err_d   = 1'b1;
      state_d = DONE;
    end else if (pend_q) begin
      tmr_d = tmr_q + 1'b1;
    end
    if (state_q == IDLE && start) begin
      state_d = RD_DFH;
      addr_d  = base_addr;
      hops_d  = '0;
      found_d = '0;
      pass_d  = '0;
      err_d   = 1'b0;
    end else if (state_q == MATCH) begin
      state_d = hit ? SCR_FIRST : NEXT;
      idx_d   = hit ? midx : idx_q;
    end else if (state_q == CHECK) begin
      // Only the first occurrence can set pass; any later failure clears it for good.
      state_d        = SCR_LAST;
      pass_d[idx_q]  = found_q[idx_q] ? pass_q[idx_q] & ok : ok;
      found_d[idx_q] = 1'b1;
    end else if (state_q == NEXT) begin
      state_d = dfh_q[24] || dfh_q[23:0] == '0 ? DONE :
                hops_q == HW'(MAX_HOPS)       ? DONE : RD_DFH;
      err_d   = err_q || (!dfh_q[24] && dfh_q[23:0] != '0 && hops_q == HW'(MAX_HOPS));
      addr_d  = addr_q + ADDR_W'(dfh_q[23:0]);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      pend_q      <= 1'b0;
      tmr_q       <= '0;
      addr_q      <= '0;
      dfh_q       <= '0;
      gl_q        <= '0;
      gh_q        <= '0;
      scr_q       <= '0;
      orig_q      <= '0;
      idx_q       <= '0;
      hops_q      <= '0;
      found_q     <= '0;
      pass_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      pend_q      <= pend_d;
      tmr_q       <= tmr_d;
      addr_q      <= addr_d;
      dfh_q       <= dfh_d;
      gl_q        <= gl_d;
      gh_q        <= gh_d;
      scr_q       <= scr_d;
      orig_q      <= orig_d;
      idx_q       <= idx_d;
      hops_q      <= hops_d;
      found_q     <= found_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_write  = req_write_q;
  assign req_addr   = req_addr_q;
  assign req_wdata  = req_wdata_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign error      = err_q;
  assign found_mask = found_q;
  assign pass_mask  = pass_q;
endmodule

// File: tb/tb_dfh_scratch_walker.sv
// tb_dfh_scratch_walker: directed bench with a CSR memory responder for dfh_scratch_walker.
module tb_dfh_scratch_walker;
  localparam int          NF  = 9;
  localparam logic [63:0] PAT = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [127:0] UNK = {64'hDEAD_0000_0000_0001, 64'hBEEF_0000_0000_0002};
`ifdef DFH_WALK_RESTORE_EN
  localparam int          RD1 = 13, WR1 = 4;
  localparam logic [63:0] SCR0 = 64'h1234, SCR1 = 64'h1234;
`else
  localparam int          RD1 = 11, WR1 = 2;
  localparam logic [63:0] SCR0 = PAT, SCR1 = PAT ^ 64'h1;
`endif

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [NF*128-1:0] tbl_guid;
  logic [NF*16-1:0] tbl_scratch;
  logic req_valid, req_ready, req_write, rsp_valid, busy, done, error;
  logic [23:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic [NF-1:0] found_mask, pass_mask;
  int checks = 0, errors = 0;
  logic [63:0] mem [int];
  bit stuck [int];
  bit stall = 0, withhold = 0, block_wr = 0;
  int n_rd = 0, n_wr = 0, n_dfh = 0;

  always #5 clk = ~clk;

  dfh_scratch_walker #(.NUM_FEAT(NF), .ADDR_W(24), .MAX_HOPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .tbl_guid(tbl_guid), .tbl_scratch(tbl_scratch),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done), .error(error),
    .found_mask(found_mask), .pass_mask(pass_mask)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] gd(input int i);
    return {64'h1111_0000_0000_0000 + 64'(i), 64'h2222_0000_0000_0000 + 64'(i)};
  endfunction

  function automatic logic [63:0] dfh(input int off, input bit eol);
    return (64'(eol) << 40) | (64'(off) << 16);
  endfunction

  task automatic node(input int a, input logic [63:0] d, input logic [127:0] g);
    mem[a] = d;
    mem[a+8] = g[63:0];
    mem[a+16] = g[127:64];
  endtask

  // Memory responder: decides ready at each falling edge, answers reads one or more cycles after accept.
  initial begin
    int cd = 0;
    bit held = 0, h_wr = 0;
    logic [63:0] rd = '0, h_wd = '0;
    logic [23:0] h_addr = '0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (!rst_n) begin
        cd = 0;
        held = 0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = rd;
        end
      end
      if (held) chk("req_stable", {req_valid, req_write, req_addr, req_wdata}, {1'b1, h_wr, h_addr, h_wd});
      req_ready = !(block_wr && req_valid && req_write) && (!stall || $urandom_range(0, 1) == 1);
      held = req_valid && !req_ready;
      h_wr = req_write;
      h_addr = req_addr;
      h_wd = req_wdata;
      if (req_valid && req_ready) begin
        if (req_write) begin
          n_wr++;
          if (!stuck.exists(int'(req_addr))) mem[int'(req_addr)] = req_wdata;
        end else begin
          n_rd++;
          if (req_addr[11:0] == 12'h0) n_dfh++;
          if (!withhold) begin
            rd = mem.exists(int'(req_addr)) ? mem[int'(req_addr)] : 64'h0;
            cd = stall ? $urandom_range(1, 3) : 1;
          end
        end
      end
    end
  end

  task automatic walk(input logic [23:0] b, input bit poke, output int n, output int rd, output int wr, output int dh);
    int r0, w0, d0;
    r0 = n_rd;
    w0 = n_wr;
    d0 = n_dfh;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("start_clr_found", found_mask, 0);
    chk("start_clr_err", error, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      base_addr = 24'h60000;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_drop", busy, 0);
    repeat (2) @(negedge clk);
    rd = n_rd - r0;
    wr = n_wr - w0;
    dh = n_dfh - d0;
  endtask

  task automatic chain1();
    mem.delete();
    stuck.delete();
    node(24'h1000, dfh(24'h1000, 0), gd(0));
    node(24'h2000, dfh(24'h1000, 0), gd(1));
    node(24'h3000, dfh(0, 1), UNK);
    mem[32'h1028] = 64'h1234;
    mem[32'h2100] = 64'h1234;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rd, wr, dh;
    for (int i = 0; i < NF; i++) begin
      tbl_guid[128*i +: 128] = gd(i);
      tbl_scratch[16*i +: 16] = i == 0 ? 16'h28 : i == 1 ? 16'h100 : i == 3 ? 16'h40 : 16'(16'h30 + 8*i);
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_write", req_write, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_masks", {found_mask, pass_mask}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", req_valid, 0);

    chain1();
    walk(24'h1000, 1, n, rd, wr, dh);
    chk("c3_found", found_mask, 9'h003);
    chk("c3_pass", pass_mask, 9'h003);
    chk("c3_error", error, 0);
    chk("c3_dfh_reads", dh, 3);
    chk("c3_reads", rd, RD1);
    chk("c3_writes", wr, WR1);
    chk("c3_scr0", mem[32'h1028], SCR0);
    chk("c3_scr1", mem[32'h2100], SCR1);
    repeat (4) @(negedge clk);
    chk("c3_hold", {found_mask, pass_mask, error}, {9'h003, 9'h003, 1'b0});

    mem.delete();
    stuck.delete();
    node(24'h10000, dfh(24'h1000, 0), gd(3));
    node(24'h11000, dfh(24'h1000, 0), gd(1));
    node(24'h12000, dfh(0, 1), gd(1));
    stuck[32'h10040] = 1;
    stuck[32'h12100] = 1;
    stall = 1;
    walk(24'h10000, 0, n, rd, wr, dh);
    stall = 0;
    chk("stuck_found", found_mask, 9'h00A);
    chk("stuck_pass", pass_mask, 9'h000);
    chk("stuck_error", error, 0);
    chk("stuck_dfh_reads", dh, 3);

    mem.delete();
    stuck.delete();
    for (int k = 0; k < 5; k++) node(24'h40000 + 24'h1000 * k, dfh(24'h1000, 0), UNK);
    walk(24'h40000, 0, n, rd, wr, dh);
    chk("hops_error", error, 1);
    chk("hops_dfh_reads", dh, 4);
    chk("hops_found", found_mask, 0);

    mem.delete();
    for (int k = 0; k < 4; k++) node(24'h50000 + 24'h1000 * k, dfh(24'h1000, k == 3), UNK);
    walk(24'h50000, 0, n, rd, wr, dh);
    chk("hops4_eol_error", error, 0);
    chk("hops4_eol_dfh", dh, 4);

    mem.delete();
    node(24'h60000, 64'h0, gd(0));
    walk(24'h60000, 0, n, rd, wr, dh);
    chk("zoff_found", found_mask, 9'h001);
    chk("zoff_pass", pass_mask, 9'h001);
    chk("zoff_dfh", dh, 1);

    mem.delete();
    node(24'hFFF000, dfh(24'h2000, 0), UNK);
    node(24'h001000, dfh(0, 1), gd(1));
    walk(24'hFFF000, 0, n, rd, wr, dh);
    chk("wrap_found", found_mask, 9'h002);
    chk("wrap_pass", pass_mask, 9'h002);
    chk("wrap_dfh", dh, 2);

    mem.delete();
    node(24'h7000, dfh(0, 1), gd(0));
    withhold = 1;
    walk(24'h7000, 0, n, rd, wr, dh);
    withhold = 0;
    chk("to_latency", n, 258);
    chk("to_error", error, 1);
    chk("to_req_valid", req_valid, 0);
    chk("to_dfh", dh, 1);

    chain1();
    block_wr = 1;
    @(negedge clk);
    start = 1'b1;
    base_addr = 24'h1000;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(req_valid && req_write) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wr_pending", req_valid && req_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_valid", req_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_masks", {found_mask, pass_mask, req_write}, 0);
    @(negedge clk);
    @(negedge clk);
    block_wr = 0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_no_req", req_valid, 0);
    walk(24'h1000, 0, n, rd, wr, dh);
    chk("rerun_found", found_mask, 9'h003);
    chk("rerun_pass", pass_mask, 9'h003);
    chk("rerun_error", error, 0);
    chk("rerun_dfh", dh, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dfh_scratch_walker.md
DFH_SCRATCH_WALKER -- requirements
Module: dfh_scratch_walker

Interface
REQ-001 SHALL have parameter NUM_FEAT, default 9, giving the number of GUID/scratch table entries.
REQ-002 SHALL have parameter ADDR_W, default 24, giving the CSR byte-address width.
REQ-003 SHALL have parameter MAX_HOPS, default 64, giving the DFH chain length limit.
REQ-004 SHALL have parameter RSP_TIMEOUT, default 256, giving the read-response timeout in cycles.
REQ-005 SHALL have parameter PATTERN, default 64'hA5A5_5A5A_0F0F_F0F0, giving the base scratch test pattern.
REQ-006 SHALL have port clk, input, width 1, as the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, width 1, as an asynchronous, active-low reset.
REQ-008 SHALL have port start, input, width 1, a one-cycle walk request.
REQ-009 SHALL have port base_addr, input, width ADDR_W, the address of the first DFH.
REQ-010 SHALL have port tbl_guid, input, width NUM_FEAT*128, with entry i at [128i+:128].
REQ-011 SHALL have port tbl_scratch, input, width NUM_FEAT*16, with entry i's scratch offset at [16i+:16].
REQ-012 SHALL have port req_valid/req_ready, output/input, width 1/1, a CSR request handshake.
REQ-013 SHALL have port req_write, output, width 1, where 1 means write.
REQ-014 SHALL have port req_addr/req_wdata, outputs, widths ADDR_W/64.
REQ-015 SHALL have port rsp_valid/rsp_rdata, inputs, widths 1/64, carrying read data.
REQ-016 SHALL have port busy/done/error, outputs, width 1 each.
REQ-017 SHALL have port found_mask/pass_mask, outputs, width NUM_FEAT each.

Function
REQ-018 SHALL hold at most one request outstanding; req_* stay stable while req_valid=1 and req_ready=0.
REQ-019 SHALL treat a write as complete on req_valid&req_ready, and a read as complete on the first rsp_valid after acceptance.
REQ-020 SHALL implement the states IDLE -> RD_DFH -> RD_GUID_L (+0x8) -> RD_GUID_H (+0x10) -> MATCH -> [WR_SCR -> RD_SCR -> CHECK] -> NEXT -> DONE/IDLE.
REQ-021 SHALL match in MATCH against the lowest-index table entry equal to {GUID_H,GUID_L}; on no match it goes to NEXT.
REQ-022 SHALL, on a match at index i, write PATTERN^i to feature_addr+tbl_scratch[i], read it back, and set found_mask[i].
REQ-023 SHALL set pass_mask[i] on the first occurrence of feature i when the readback equals the pattern.
REQ-024 SHALL clear pass_mask[i] on any failing occurrence and leave it clear for the rest of the walk.
REQ-025 SHALL, in NEXT, take next offset = DFH[39:16] and EOL = DFH[40]; it ends the walk if EOL=1 or offset=0, else sets addr += offset (mod 2^ADDR_W) and goes to RD_DFH.
REQ-026 SHALL set error and end the walk when the hop count reaches MAX_HOPS without termination.
REQ-027 SHALL set error and end the walk when rsp_valid is absent RSP_TIMEOUT cycles after read acceptance.
REQ-028 SHALL pulse done for exactly one cycle when the walk ends and return to IDLE.
REQ-029 SHALL keep busy=1 from the cycle after start until the done cycle.
REQ-030 SHALL ignore start while busy; start in IDLE clears found_mask, pass_mask and error.
REQ-031 SHALL ignore rsp_valid with no read outstanding.
REQ-032 SHALL keep found_mask, pass_mask and error stable after done until the next start.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-walk, immediately go to IDLE and drive req_valid, req_write, busy, done, error=0, found_mask, pass_mask=0, and req_addr, req_wdata=0.
REQ-034 SHALL, after reset, drop any in-flight response and issue no request until start.

Configuration
REQ-035 SHALL, with DFH_WALK_RESTORE_EN defined, insert RD_ORIG before WR_SCR and WR_RESTORE after CHECK, so the original scratch value is written back; a restore write is issued even on pass/fail mismatch.
REQ-036 SHALL, without DFH_WALK_RESTORE_EN, perform exactly one write and one read per matched feature and leave the pattern in scratch.

Verification
REQ-037 SHALL cover a 3-node chain (FME GUID scratch 0x28, HE_LB 0x100, unknown GUID, EOL on node 3) -> found_mask=...011, pass_mask=...011, done after 3 DFH reads, error=0.
REQ-038 SHALL cover an HE_MEM scratch stuck at 0 -> found bit 3 set, pass bit 3 clear, error=0.
REQ-039 SHALL cover a chain with next offset never 0 and no EOL, MAX_HOPS=4 -> error=1 after 4 DFH reads, done pulse.
REQ-040 SHALL cover a read response withheld for 256 cycles -> error=1, done, req_valid=0.
REQ-041 SHALL cover rst_n dropped during WR_SCR with req_valid=1 -> req_valid=0 asynchronously; the next start completes normally.
REQ-042 SHALL cover a build with DFH_WALK_RESTORE_EN and scratch preloaded with 0x1234 -> scratch=0x1234 after done, 4 scratch accesses per feature.
